rvfi_trace_monitor: RTL and testbench
=====================================

RVFI_TRACE_MONITOR -- requirements
Module: rvfi_trace_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4: record FIFO depth; power of two, at least 2.
REQ-002 SHALL have parameter SEQ_W, default 16: width of the sequence field carried in each header word.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rvfi_valid, input, 1 bit: one instruction retires this cycle.
REQ-006 SHALL have ports rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata, input, 32 bits each: the retired instruction's RVFI fields.
REQ-007 SHALL have port rvfi_rd_addr, input, 5 bits: destination register of the retired instruction.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 32), out_last (output, 1): outbound trace word stream.
REQ-009 SHALL have port retire_cnt, output, 32 bits: number of records accepted.
REQ-010 SHALL have port drop_cnt, output, 16 bits: number of records dropped.
REQ-011 SHALL have ports err_pc, err_x0, overflow, output, 1 bit each: sticky error flags.

Function
REQ-012 SHALL never back-pressure RVFI; a record is captured on every clk edge where rvfi_valid=1, unless the FIFO is full (REQ-014).
REQ-013 SHALL store per record: pc_rdata, insn, rd_wdata, rd_addr, the SEQ_W-bit sequence number (equal to retire_cnt[SEQ_W-1:0] before increment), and flag bits pc_bad and x0_bad.
REQ-014 FIFO full with no pop on the same edge: SHALL drop the record, set overflow, and increment drop_cnt (saturating at 0xFFFF); retire_cnt SHALL not increment.
REQ-015 FIFO full with a pop (last word handshake) on the same edge: SHALL accept the push.
REQ-016 retire_cnt SHALL wrap modulo 2^32.
REQ-017 Serializer states SHALL be IDLE, HDR, PC, INSN, WDATA, visited in that order.
- IDLE->HDR when the FIFO is non-empty.
- Each other state advances only on out_valid && out_ready.
- WDATA -> HDR if the FIFO is still non-empty after the pop, otherwise -> IDLE.
REQ-018 Header word SHALL be {seq[15:0], 6'b0, x0_bad, pc_bad, 3'b0, rd_addr}; with SEQ_W<16, seq SHALL be zero-extended.
REQ-019 out_valid SHALL be 1 exactly in HDR/PC/INSN/WDATA; out_data and out_last SHALL be stable while out_valid && !out_ready.
REQ-020 out_last SHALL be 1 only in WDATA; the FIFO entry SHALL pop on the WDATA handshake.
REQ-021 Latency: a record captured into an empty FIFO at edge N SHALL present its header with out_valid=1 in the cycle after edge N+1.
REQ-022 x0_bad SHALL be set when rd_addr==0 and rd_wdata!=0; err_x0 SHALL then be set sticky.
REQ-023 The monitor SHALL retain last_pc_wdata from the most recent valid retirement, including dropped records.

Reset
REQ-024 During rst=0: FIFO empty, state IDLE, out_valid=0, out_last=0, out_data=0, retire_cnt=0, drop_cnt=0, err_pc=0, err_x0=0, overflow=0, last-PC-known=0.
REQ-025 Assertion of rst mid-record SHALL abort the record immediately and discard all FIFO contents.
REQ-026 The first rvfi_valid after rst deasserts SHALL be accepted normally.

Configuration
REQ-027 With RVFI_MON_PC_CHECK_EN defined: pc_bad SHALL be set when last-PC-known=1 and rvfi_pc_rdata != last_pc_wdata; err_pc SHALL then be set sticky.
REQ-028 With RVFI_MON_PC_CHECK_EN defined: the first retirement after reset SHALL not be checked.
REQ-029 Without RVFI_MON_PC_CHECK_EN: pc_bad and err_pc SHALL be tied 0, and the last-PC register SHALL not exist.

Structure
REQ-030 The package rvfi_mon_pkg SHALL hold:
- the record struct typedef
- the serializer state enum
- header field offset constants
REQ-031 The FIFO SHALL be the sub-module rvfi_rec_fifo: parameterized by DEPTH, storing the record type, wrap-around pointers with an extra bit for full/empty.

Verification
REQ-032 Single retire, pc_rdata=0x100, insn=0x00500093, rd=1, wdata=5, out_ready=1: words 0x00000001, 0x100, 0x00500093, 0x5; out_last on the 4th; retire_cnt=1.
REQ-033 Retirements at PC 0x100 then 0x200, with first pc_wdata=0x104 and the PC check enabled: second header pc_bad=1 (bit 8), err_pc=1; with the macro undefined, err_pc=0.
REQ-034 rd=0, wdata=0x7: header bit 9=1, err_x0=1.
REQ-035 out_ready=0, 6 consecutive retirements, DEPTH=4: records 0-3 emitted later with seq 0-3; overflow=1; drop_cnt=2; retire_cnt=4.
REQ-036 FIFO full, 5th retirement on the same edge as the WDATA handshake: record accepted, no drop, seq=4.
REQ-037 rst pulled low during the INSN word: out_valid=0 asynchronously; after release, the next retirement emits seq 0.

Source files
------------

// File: rtl/rvfi_mon_pkg.sv
// Shared types for the RVFI trace monitor: the per-retirement record, the
// serializer state encoding and the header word layout.
package rvfi_mon_pkg;

  localparam int HDR_RD_LSB     = 0;
  localparam int HDR_PC_BAD_BIT = 8;
  localparam int HDR_X0_BAD_BIT = 9;
  localparam int HDR_SEQ_LSB    = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_PC    = 3'd2,
    S_INSN  = 3'd3,
    S_WDATA = 3'd4
  } ser_state_e;

  // seq holds the low 16 bits of the sequence number, zero-extended when SEQ_W < 16
  typedef struct packed {
    logic [31:0] pc_rdata;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic [15:0] seq;
    logic        pc_bad;
    logic        x0_bad;
  } rec_t;

  function automatic logic [31:0] hdr_word(input rec_t r);
    logic [31:0] w;
    w = '0;
    w[HDR_SEQ_LSB +: 16] = r.seq;
    w[HDR_X0_BAD_BIT]    = r.x0_bad;
    w[HDR_PC_BAD_BIT]    = r.pc_bad;
    w[HDR_RD_LSB +: 5]   = r.rd_addr;
    return w;
  endfunction

endpackage

// File: rtl/rvfi_rec_fifo.sv
// Record FIFO for the trace monitor: DEPTH entries (power of two), pointers
// carry one extra wrap bit so full and empty are distinguishable.
module rvfi_rec_fifo
  import rvfi_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t push_rec,
  input  logic pop,
  output rec_t head_rec,
  output rec_t next_rec,
  output logic empty,
  output logic full,
  output logic multi
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   used;
  logic [AW-1:0] rd_idx_nxt;
  logic          push_en;
  logic          pop_en;
  rec_t          mem_q [DEPTH];

  always_comb begin
    used       = wr_ptr_q - rd_ptr_q;
    empty      = (used == '0);
    full       = (used == FULL_CNT);
    multi      = (used > PTR_ONE);
    pop_en     = pop && !empty;
    // a push into a full FIFO is legal when the head leaves on the same edge
    push_en    = push && (!full || pop_en);
    wr_ptr_d   = push_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop_en  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rd_idx_nxt = rd_ptr_q[AW-1:0] + AW'(1);
    head_rec   = mem_q[rd_ptr_q[AW-1:0]];
    next_rec   = mem_q[rd_idx_nxt];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
  end

endmodule

// File: rtl/rvfi_trace_monitor.sv
// RVFI retirement monitor: captures records into a FIFO and streams each as
// four 32-bit words. Define RVFI_MON_PC_CHECK_EN to enable PC-continuity checks.
module rvfi_trace_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rvfi_valid,
  input  logic [31:0] rvfi_insn,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [4:0]  rvfi_rd_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [31:0] retire_cnt,
  output logic [15:0] drop_cnt,
  output logic        err_pc,
  output logic        err_x0,
  output logic        overflow
);

  localparam logic [31:0] SEQ_MASK =
    (SEQ_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << SEQ_W) - 32'd1);

  ser_state_e  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [31:0] out_data_q, out_data_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        err_x0_q, err_x0_d;
  logic        overflow_q, overflow_d;

  logic hs, pop, push, drop, x0_bad, pc_bad;
  logic fifo_empty, fifo_full, fifo_multi;
  rec_t push_rec, head_rec, next_rec;

`ifdef RVFI_MON_PC_CHECK_EN
  logic [31:0] last_pc_q, last_pc_d;
  logic        last_pc_known_q, last_pc_known_d;
  logic        err_pc_q, err_pc_d;

  // every valid retirement updates the reference PC, dropped ones included
  always_comb begin
    pc_bad          = last_pc_known_q && (rvfi_pc_rdata != last_pc_q);
    last_pc_d       = rvfi_valid ? rvfi_pc_wdata : last_pc_q;
    last_pc_known_d = last_pc_known_q | rvfi_valid;
    err_pc_d        = err_pc_q | (rvfi_valid & pc_bad);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pc_known_q <= 1'b0;
      err_pc_q        <= 1'b0;
    end else begin
      last_pc_known_q <= last_pc_known_d;
      err_pc_q        <= err_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    last_pc_q <= last_pc_d;
  end

  assign err_pc = err_pc_q;
`else
  logic unused_pc_wdata;
  assign unused_pc_wdata = ^rvfi_pc_wdata;
  assign pc_bad          = 1'b0;
  assign err_pc          = 1'b0;
`endif

  always_comb begin
    hs     = out_valid_q && out_ready;
    pop    = (state_q == S_WDATA) && hs;
    push   = rvfi_valid && (!fifo_full || pop);
    drop   = rvfi_valid && fifo_full && !pop;
    x0_bad = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);

    push_rec.pc_rdata = rvfi_pc_rdata;
    push_rec.insn     = rvfi_insn;
    push_rec.rd_wdata = rvfi_rd_wdata;
    push_rec.rd_addr  = rvfi_rd_addr;
    push_rec.seq      = 16'(retire_cnt_q & SEQ_MASK);
    push_rec.pc_bad   = pc_bad;
    push_rec.x0_bad   = x0_bad;

    retire_cnt_d = push ? retire_cnt_q + 32'd1 : retire_cnt_q;
    drop_cnt_d   = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    overflow_d   = overflow_q | drop;
    err_x0_d     = err_x0_q | (rvfi_valid & x0_bad);
  end

  rvfi_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .head_rec (head_rec),
    .next_rec (next_rec),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .multi    (fifo_multi)
  );

  // outputs are computed one state ahead so they come straight from flops
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        state_d     = S_HDR;
        out_valid_d = 1'b1;
        out_data_d  = hdr_word(head_rec);
      end
      S_HDR: if (hs) begin
        state_d    = S_PC;
        out_data_d = head_rec.pc_rdata;
      end
      S_PC: if (hs) begin
        state_d    = S_INSN;
        out_data_d = head_rec.insn;
      end
      S_INSN: if (hs) begin
        state_d    = S_WDATA;
        out_data_d = head_rec.rd_wdata;
        out_last_d = 1'b1;
      end
      S_WDATA: if (hs) begin
        out_last_d = 1'b0;
        // the next head is either the second entry or the record pushed right now
        if (fifo_multi || push) begin
          state_d    = S_HDR;
          out_data_d = hdr_word(fifo_multi ? next_rec : push_rec);
        end else begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      err_x0_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      err_x0_q     <= err_x0_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_data_q;
  assign retire_cnt = retire_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign err_x0     = err_x0_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rvfi_trace_monitor.sv
// Directed bench for rvfi_trace_monitor: a vector table of single retirements
// plus hand-written overflow, full-with-pop and mid-record reset sequences.
module tb_rvfi_trace_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [31:0] rvfi_insn = '0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [31:0] rvfi_pc_wdata = '0;
  logic [31:0] rvfi_rd_wdata = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic [31:0] retire_cnt;
  logic [15:0] drop_cnt;
  logic        err_pc;
  logic        err_x0;
  logic        overflow;

  int errors = 0;
  int checks = 0;

`ifdef RVFI_MON_PC_CHECK_EN
  localparam bit PC_CHK = 1'b1;
`else
  localparam bit PC_CHK = 1'b0;
`endif

  rvfi_trace_monitor #(.DEPTH(4), .SEQ_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rvfi_valid    (rvfi_valid),
    .rvfi_insn     (rvfi_insn),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_pc_wdata (rvfi_pc_wdata),
    .rvfi_rd_wdata (rvfi_rd_wdata),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .retire_cnt    (retire_cnt),
    .drop_cnt      (drop_cnt),
    .err_pc        (err_pc),
    .err_x0        (err_x0),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] pcw;
    logic [31:0] hdr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rvfi(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                          input logic [31:0] wdata, input logic [31:0] pcw);
    rvfi_pc_rdata = pc;
    rvfi_insn     = insn;
    rvfi_rd_addr  = rd;
    rvfi_rd_wdata = wdata;
    rvfi_pc_wdata = pcw;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                        input logic [31:0] wdata, input logic [31:0] pcw);
    set_rvfi(pc, insn, rd, wdata, pcw);
    rvfi_valid = 1'b1;
    tick();
    rvfi_valid = 1'b0;
  endtask

  // waits (bounded) for out_valid, samples the word, and lets it be consumed
  task automatic get_word(output logic [31:0] d, output logic l, output int waits);
    waits = 0;
    while (!out_valid && waits < 20) begin
      tick();
      waits++;
    end
    d = out_data;
    l = out_last;
    if (out_valid) tick();
    else waits = -1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    rvfi_valid = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b1;
    tick();
  endtask

  // collects one record (4 words) with out_ready high and checks it
  task automatic expect_record(input string tag, input logic [31:0] hdr, input logic [31:0] pc,
                               input logic [31:0] insn, input logic [31:0] wdata);
    logic [31:0] d;
    logic        l;
    int          waits;
    logic [31:0] exp_w [4];
    exp_w[0] = hdr;
    exp_w[1] = pc;
    exp_w[2] = insn;
    exp_w[3] = wdata;
    for (int w = 0; w < 4; w++) begin
      get_word(d, l, waits);
      if (waits < 0) check($sformatf("%s_w%0d_timeout", tag, w), 32'(waits), 32'd0);
      check($sformatf("%s_w%0d_data", tag, w), d, exp_w[w]);
      check($sformatf("%s_w%0d_last", tag, w), {31'd0, l}, {31'd0, (w == 3)});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        l;
    int          waits;

    vecs[0] = '{pc: 32'h0000_0100, insn: 32'h0050_0093, rd: 5'd1,  wdata: 32'h0000_0005,
                pcw: 32'h0000_0104, hdr: 32'h0000_0001};
    vecs[1] = '{pc: 32'h0000_0200, insn: 32'h0000_0013, rd: 5'd0,  wdata: 32'h0000_0000,
                pcw: 32'h0000_0204, hdr: (PC_CHK ? 32'h0001_0100 : 32'h0001_0000)};
    vecs[2] = '{pc: 32'h0000_0204, insn: 32'h0070_0013, rd: 5'd0,  wdata: 32'h0000_0007,
                pcw: 32'h0000_0208, hdr: 32'h0002_0200};
    vecs[3] = '{pc: 32'h0000_0208, insn: 32'h01f0_0f93, rd: 5'd31, wdata: 32'hFFFF_FFFF,
                pcw: 32'h0000_020C, hdr: 32'h0003_001F};
    vecs[4] = '{pc: 32'h0000_020C, insn: 32'h1234_5537, rd: 5'd10, wdata: 32'hDEAD_BEEF,
                pcw: 32'h0000_0210, hdr: 32'h0004_000A};

    // reset state while rst is held low
    tick();
    check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_out_last",   {31'd0, out_last},  32'd0);
    check("rst_out_data",   out_data,           32'd0);
    check("rst_retire_cnt", retire_cnt,         32'd0);
    check("rst_drop_cnt",   {16'd0, drop_cnt},  32'd0);
    check("rst_err_pc",     {31'd0, err_pc},    32'd0);
    check("rst_err_x0",     {31'd0, err_x0},    32'd0);
    check("rst_overflow",   {31'd0, overflow},  32'd0);
    #3;
    rst = 1'b1;
    tick();

    // vector table: one retirement each, streamed with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      retire(vecs[i].pc, vecs[i].insn, vecs[i].rd, vecs[i].wdata, vecs[i].pcw);
      get_word(d, l, waits);
      check($sformatf("v%0d_latency", i), 32'(waits), 32'd1);
      check($sformatf("v%0d_hdr", i), d, vecs[i].hdr);
      check($sformatf("v%0d_hdr_last", i), {31'd0, l}, 32'd0);
      for (int w = 1; w < 4; w++) begin
        get_word(d, l, waits);
        check($sformatf("v%0d_w%0d_wait", i, w), 32'(waits), 32'd0);
        check($sformatf("v%0d_w%0d_data", i, w), d,
              (w == 1) ? vecs[i].pc : (w == 2) ? vecs[i].insn : vecs[i].wdata);
        check($sformatf("v%0d_w%0d_last", i, w), {31'd0, l}, {31'd0, (w == 3)});
      end
      check($sformatf("v%0d_idle", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("v%0d_err_x0", i), {31'd0, err_x0}, {31'd0, (i >= 2)});
      check($sformatf("v%0d_err_pc", i), {31'd0, err_pc}, {31'd0, (PC_CHK && i >= 1)});
    end
    check("tbl_retire_cnt", retire_cnt, 32'd5);
    check("tbl_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("tbl_overflow", {31'd0, overflow}, 32'd0);

    // overflow: six back-to-back retirements into a stalled stream
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_rvfi(32'h1000 + 32'(4 * i), 32'h0000_0013, 5'(i + 1), 32'(i), 32'h1004 + 32'(4 * i));
      rvfi_valid = 1'b1;
      tick();
    end
    rvfi_valid = 1'b0;
    check("ovf_overflow",   {31'd0, overflow},  32'd1);
    check("ovf_drop_cnt",   {16'd0, drop_cnt},  32'd2);
    check("ovf_retire_cnt", retire_cnt,         32'd4);
    check("ovf_out_valid",  {31'd0, out_valid}, 32'd1);
    check("ovf_hdr0",       out_data,           32'h0000_0001);
    tick();
    tick();
    check("ovf_hdr0_stable", out_data, 32'h0000_0001);
    check("ovf_last_stable", {31'd0, out_last}, 32'd0);
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++)
      expect_record($sformatf("ovf_r%0d", r), (32'(r) << 16) | 32'(r + 1),
                    32'h1000 + 32'(4 * r), 32'h0000_0013, 32'(r));
    check("ovf_drained", {31'd0, out_valid}, 32'd0);

    // full FIFO, push lands on the same edge as the WDATA handshake
    do_reset();
    for (int i = 0; i < 4; i++)
      retire(32'h2000 + 32'(4 * i), 32'h0000_0013, 5'(i + 1), 32'h50 + 32'(i), 32'h2004 + 32'(4 * i));
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("fp_in_wdata_last", {31'd0, out_last}, 32'd1);
    set_rvfi(32'h2010, 32'h0000_0013, 5'd5, 32'h54, 32'h2014);
    rvfi_valid = 1'b1;
    tick();
    rvfi_valid = 1'b0;
    check("fp_drop_cnt",   {16'd0, drop_cnt},  32'd0);
    check("fp_overflow",   {31'd0, overflow},  32'd0);
    check("fp_retire_cnt", retire_cnt,         32'd5);
    check("fp_back2back",  {31'd0, out_valid}, 32'd1);
    for (int r = 1; r < 5; r++)
      expect_record($sformatf("fp_r%0d", r), (32'(r) << 16) | 32'(r + 1),
                    32'h2000 + 32'(4 * r), 32'h0000_0013, 32'h50 + 32'(r));

    // reset asserted while the INSN word is on the bus
    do_reset();
    out_ready = 1'b1;
    retire(32'h0000_0300, 32'h0010_0113, 5'd2, 32'h1, 32'h0000_0304);
    get_word(d, l, waits);
    check("mr_hdr", d, 32'h0000_0002);
    get_word(d, l, waits);
    check("mr_pc", d, 32'h0000_0300);
    check("mr_insn_on_bus", out_data, 32'h0010_0113);
    #2;
    rst = 1'b0;
    #1;
    check("mr_async_valid", {31'd0, out_valid}, 32'd0);
    check("mr_async_data",  out_data,           32'd0);
    check("mr_async_cnt",   retire_cnt,         32'd0);
    tick();
    tick();
    #3;
    rst = 1'b1;
    tick();
    check("mr_fifo_flushed", {31'd0, out_valid}, 32'd0);
    retire(32'h0000_0400, 32'h0000_0013, 5'd3, 32'h0, 32'h0000_0404);
    expect_record("mr_after", 32'h0000_0003, 32'h0000_0400, 32'h0000_0013, 32'h0);
    check("mr_retire_cnt", retire_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
